// File: rtl/vedic_mult_seq_if.sv
// Operand/result handshake bundle for vedic_mult_seq.
// master drives operands and out_ready; slave is the multiplier.
interface vedic_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_product, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_product, busy
    );
endinterface

// File: rtl/vedic_mult_seq.sv
// Sequential signed/unsigned WIDTH x WIDTH multiplier built around one
// recursive Urdhva-Tiryagbhyam (WIDTH/2)x(WIDTH/2) core reused over four quadrants.
module vedic_core #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_p
);
    generate
        if (N == 2) begin : g_cell
            logic w_c1, w_c2, w_k, w_t;
            assign w_c1 = i_a[1] & i_b[0];
            assign w_c2 = i_a[0] & i_b[1];
            assign w_k  = w_c1 & w_c2;
            assign w_t  = i_a[1] & i_b[1];
            assign o_p  = {w_t & w_k, w_t ^ w_k, w_c1 ^ w_c2, i_a[0] & i_b[0]};
        end else begin : g_split
            localparam int unsigned M  = N / 2;
            localparam int unsigned PW = 2 * N;
            logic [N-1:0]  w_ll, w_hl, w_lh, w_hh;
            logic [PW-1:0] w_t0, w_t1, w_t2, w_s, w_c;

            vedic_core #(.N(M)) u_ll (.i_a(i_a[M-1:0]), .i_b(i_b[M-1:0]), .o_p(w_ll));
            vedic_core #(.N(M)) u_hl (.i_a(i_a[N-1:M]), .i_b(i_b[M-1:0]), .o_p(w_hl));
            vedic_core #(.N(M)) u_lh (.i_a(i_a[M-1:0]), .i_b(i_b[N-1:M]), .o_p(w_lh));
            vedic_core #(.N(M)) u_hh (.i_a(i_a[N-1:M]), .i_b(i_b[N-1:M]), .o_p(w_hh));

            // Outer products never overlap, so they share one row of the 3:2 compressor.
            assign w_t0 = {w_hh, w_ll};
            assign w_t1 = PW'(w_hl) << M;
            assign w_t2 = PW'(w_lh) << M;
            assign w_s  = w_t0 ^ w_t1 ^ w_t2;
            assign w_c  = ((w_t0 & w_t1) | (w_t0 & w_t2) | (w_t1 & w_t2)) << 1;
            assign o_p  = w_s + w_c;
        end
    endgenerate
endmodule

module vedic_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    vedic_mult_seq_if.slave bus
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          r_state;
    logic [1:0]      r_q;
    logic [H-1:0]    r_a_lo, r_a_hi, r_b_lo, r_b_hi;
    logic            r_neg;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_product;

    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [H-1:0]     w_x, w_y;
    logic [WIDTH-1:0] w_pp;
    logic [PW-1:0]    w_pp_shifted;
    logic [PW-1:0]    w_sum;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign w_mag_a = (bus.in_signed && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
    assign w_mag_b = (bus.in_signed && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;

    assign w_x = r_q[0] ? r_a_hi : r_a_lo;
    assign w_y = r_q[1] ? r_b_hi : r_b_lo;

    vedic_core #(.N(H)) u_core (
        .i_a (w_x),
        .i_b (w_y),
        .o_p (w_pp)
    );

    always_comb begin
        w_pp_shifted = PW'(w_pp);
        unique case (r_q)
            2'd0:       w_pp_shifted = PW'(w_pp);
            2'd1, 2'd2: w_pp_shifted = PW'(w_pp) << H;
            2'd3:       w_pp_shifted = PW'(w_pp) << WIDTH;
            default:    w_pp_shifted = PW'(w_pp);
        endcase
    end

    assign w_sum = r_acc + w_pp_shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_q       <= 2'd0;
            r_a_lo    <= '0;
            r_a_hi    <= '0;
            r_b_lo    <= '0;
            r_b_hi    <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        {r_a_hi, r_a_lo} <= w_mag_a;
                        {r_b_hi, r_b_lo} <= w_mag_b;
                        r_neg   <= bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
                        r_acc   <= '0;
                        r_q     <= 2'd0;
                        r_state <= StCalc;
                    end
                end
                StCalc: begin
                    r_acc <= w_sum;
                    r_q   <= r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        r_product <= r_neg ? -w_sum : w_sum;
                        r_state   <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == StIdle);
    assign bus.out_valid   = (r_state == StDone);
    assign bus.busy        = (r_state != StIdle);
    assign bus.out_product = r_product;
endmodule
